chirp_scheduler: RTL and testbench

//  Sequencer for the Chirp NCO-sweep datapath. Holds a small table of chirp profiles
//  (start/end control word, rate step, rate divider, inter-sweep delay, repeat count)
//  and plays them in order: loads one profile onto the Chirp inputs, counts completed

---
 rtl/chirp_pkg.sv | 49 ++++
 rtl/chirp_profile_ram.sv | 32 +++
 rtl/chirp_scheduler.sv | 151 +++++++++++++++
 tb/tb_chirp_scheduler.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/chirp_pkg.sv
// Shared types for the chirp profile sequencer: FSM states, profile record, drive record.
package chirp_pkg;

    localparam int CTRL_W        = 32;
    localparam int RATE_W        = 16;
    localparam int DELAY_W       = 4;
    localparam int PROF_REPEAT_W = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        NEXT = 3'd3,
        DONE = 3'd4
    } state_t;

    typedef struct packed {
        logic [CTRL_W-1:0]        start_ctrl;
        logic [CTRL_W-1:0]        end_ctrl;
        logic [RATE_W-1:0]        prp;
        logic [RATE_W-1:0]        inv;
        logic [DELAY_W-1:0]       dly;
        logic [PROF_REPEAT_W-1:0] rpt;
    } profile_t;

    // The subset of a profile that is presented to the Chirp instance.
    typedef struct packed {
        logic [CTRL_W-1:0]  start_ctrl;
        logic [CTRL_W-1:0]  end_ctrl;
        logic [RATE_W-1:0]  prp;
        logic [RATE_W-1:0]  inv;
        logic [DELAY_W-1:0] dly;
    } drive_t;

    function automatic drive_t to_drive(input profile_t p);
        drive_t d;
        d.start_ctrl = p.start_ctrl;
        d.end_ctrl   = p.end_ctrl;
        d.prp        = p.prp;
        d.inv        = p.inv;
        d.dly        = p.dly;
        return d;
    endfunction

    function automatic logic [PROF_REPEAT_W-1:0] eff_repeat(input logic [PROF_REPEAT_W-1:0] r);
        return (r == '0) ? PROF_REPEAT_W'(1) : r;
    endfunction

endpackage

// File: rtl/chirp_profile_ram.sv
// Profile table: register file with one write port and one asynchronous read port.
// Cleared synchronously on reset; a same-cycle write is visible to reads only after the edge.
module chirp_profile_ram
    import chirp_pkg::*;
#(
    parameter int NUM_PROFILES = 4,
    parameter int ADDR_W       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  profile_t          wr_dat_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output profile_t          rd_dat_o
);

    profile_t mem_q [NUM_PROFILES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PROFILES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
    end

    assign rd_dat_o = mem_q[rd_addr_i];

endmodule

// File: rtl/chirp_scheduler.sv
// Plays a table of chirp profiles onto the Chirp inputs, counting sweeps on nco_reset rising edges.
// start -> outputs valid two edges later; stop aborts to IDLE on the next edge without a done pulse.
module chirp_scheduler
    import chirp_pkg::*;
#(
    parameter int NUM_PROFILES = 4,
    parameter int ADDR_W       = 2,
    parameter int REPEAT_W     = PROF_REPEAT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic [CTRL_W-1:0]   cfg_start,
    input  logic [CTRL_W-1:0]   cfg_end,
    input  logic [RATE_W-1:0]   cfg_prp,
    input  logic [RATE_W-1:0]   cfg_inv,
    input  logic [DELAY_W-1:0]  cfg_delay,
    input  logic [REPEAT_W-1:0] cfg_repeat,
    input  logic [ADDR_W-1:0]   last_idx,
    input  logic                loop_en,
    input  logic                start,
    input  logic                stop,
    input  logic                nco_reset_in,
    output logic                chirp_en,
    output logic [CTRL_W-1:0]   start_ctrl,
    output logic [CTRL_W-1:0]   end_ctrl,
    output logic [RATE_W-1:0]   prp_rate,
    output logic [RATE_W-1:0]   inv_rate,
    output logic [DELAY_W-1:0]  delay,
    output logic [ADDR_W-1:0]   profile_idx,
    output logic                busy,
    output logic                done
);

    state_t                   state_q;
    logic [ADDR_W-1:0]        idx_q;
    logic [ADDR_W-1:0]        profile_idx_q;
    logic [REPEAT_W-1:0]      sweep_cnt_q;
    logic                     nco_prev_q;
    logic                     chirp_en_q;
    logic                     done_q;
    profile_t                 prof_q;
    drive_t                   drv_q;
    profile_t                 wr_prof;
    profile_t                 rd_prof;
    logic                     sweep_edge;

    assign wr_prof = '{start_ctrl: cfg_start, end_ctrl: cfg_end, prp: cfg_prp,
                       inv: cfg_inv, dly: cfg_delay, rpt: cfg_repeat};

    chirp_profile_ram #(
        .NUM_PROFILES (NUM_PROFILES),
        .ADDR_W       (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .we_i      (cfg_we),
        .wr_addr_i (cfg_addr),
        .wr_dat_i  (wr_prof),
        .rd_addr_i (idx_q),
        .rd_dat_o  (rd_prof)
    );

    assign sweep_edge = nco_reset_in && !nco_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            profile_idx_q <= '0;
            sweep_cnt_q   <= '0;
            nco_prev_q    <= 1'b0;
            chirp_en_q    <= 1'b0;
            done_q        <= 1'b0;
            prof_q        <= '0;
            drv_q         <= '0;
        end else begin
            done_q <= 1'b0;
            if (stop && state_q != IDLE) begin
                state_q       <= IDLE;
                idx_q         <= '0;
                profile_idx_q <= '0;
                chirp_en_q    <= 1'b0;
                drv_q         <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start && !stop) begin
                            state_q <= LOAD;
                            idx_q   <= '0;
                        end
                    end
                    LOAD: begin
                        // Shadow copy: later table writes to this index wait for the next LOAD.
                        prof_q      <= rd_prof;
                        sweep_cnt_q <= '0;
                        nco_prev_q  <= 1'b1;
                        state_q     <= RUN;
                    end
                    RUN: begin
                        nco_prev_q    <= nco_reset_in;
                        drv_q         <= to_drive(prof_q);
                        profile_idx_q <= idx_q;
                        chirp_en_q    <= 1'b1;
                        if (sweep_edge) begin
                            if (REPEAT_W'(sweep_cnt_q + 1'b1) == eff_repeat(prof_q.rpt)) begin
                                state_q    <= NEXT;
                                chirp_en_q <= 1'b0;
                            end else begin
                                sweep_cnt_q <= REPEAT_W'(sweep_cnt_q + 1'b1);
                            end
                        end
                    end
                    NEXT: begin
                        if (idx_q == last_idx) begin
                            if (loop_en) begin
                                idx_q   <= '0;
                                state_q <= LOAD;
                            end else begin
                                state_q       <= DONE;
                                done_q        <= 1'b1;
                                drv_q         <= '0;
                                profile_idx_q <= '0;
                            end
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= LOAD;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign chirp_en    = chirp_en_q;
    assign start_ctrl  = drv_q.start_ctrl;
    assign end_ctrl    = drv_q.end_ctrl;
    assign prp_rate    = drv_q.prp;
    assign inv_rate    = drv_q.inv;
    assign delay       = drv_q.dly;
    assign profile_idx = profile_idx_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;

endmodule

// File: tb/tb_chirp_scheduler.sv
// Directed bench for chirp_scheduler: reset, single profile, looping sequence, repeat=0, start/stop, shadow writes.
module tb_chirp_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [31:0] cfg_start = '0;
    logic [31:0] cfg_end = '0;
    logic [15:0] cfg_prp = '0;
    logic [15:0] cfg_inv = '0;
    logic [3:0]  cfg_delay = '0;
    logic [7:0]  cfg_repeat = '0;
    logic [1:0]  last_idx = '0;
    logic        loop_en = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        nco_reset_in = 1'b0;
    logic        chirp_en;
    logic [31:0] start_ctrl;
    logic [31:0] end_ctrl;
    logic [15:0] prp_rate;
    logic [15:0] inv_rate;
    logic [3:0]  delay;
    logic [1:0]  profile_idx;
    logic        busy;
    logic        done;

    int total = 0;
    int passed = 0;
    int done_cnt = 0;
    int done_snap;

    chirp_scheduler #(.NUM_PROFILES(4), .ADDR_W(2), .REPEAT_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_start(cfg_start), .cfg_end(cfg_end), .cfg_prp(cfg_prp), .cfg_inv(cfg_inv),
        .cfg_delay(cfg_delay), .cfg_repeat(cfg_repeat), .last_idx(last_idx),
        .loop_en(loop_en), .start(start), .stop(stop), .nco_reset_in(nco_reset_in),
        .chirp_en(chirp_en), .start_ctrl(start_ctrl), .end_ctrl(end_ctrl),
        .prp_rate(prp_rate), .inv_rate(inv_rate), .delay(delay),
        .profile_idx(profile_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] s, input logic [31:0] e,
                             input logic [15:0] p, input logic [15:0] i, input logic [3:0] d,
                             input logic [7:0] r);
        cfg_we = 1'b1; cfg_addr = a; cfg_start = s; cfg_end = e;
        cfg_prp = p; cfg_inv = i; cfg_delay = d; cfg_repeat = r;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic pulse();
        nco_reset_in = 1'b1;
        step();
        nco_reset_in = 1'b0;
        step();
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0h exp 0", busy); else passed++;
        total++; if (chirp_en !== 1'b0) $display("FAIL reset_chirp_en: got %0h exp 0", chirp_en); else passed++;
        total++; if (start_ctrl !== 32'h0) $display("FAIL reset_start_ctrl: got %0h exp 0", start_ctrl); else passed++;
        cfg_write(2'd0, 32'hAAAA, 32'hBBBB, 16'h5, 16'h1, 4'h3, 8'd2);
        last_idx = 2'd0; loop_en = 1'b0;
        kick(); step(); step();
        total++; if (start_ctrl !== 32'hAAAA) $display("FAIL pre_rst_start_ctrl: got %0h exp aaaa", start_ctrl); else passed++;
        rst = 1'b1;
        repeat (3) step();
        total++; if (busy !== 1'b0) $display("FAIL midrun_rst_busy: got %0h exp 0", busy); else passed++;
        total++; if (chirp_en !== 1'b0) $display("FAIL midrun_rst_chirp_en: got %0h exp 0", chirp_en); else passed++;
        total++; if (end_ctrl !== 32'h0) $display("FAIL midrun_rst_end_ctrl: got %0h exp 0", end_ctrl); else passed++;
        rst = 1'b0;
        kick(); step(); step();
        total++; if (chirp_en !== 1'b1) $display("FAIL cleared_table_chirp_en: got %0h exp 1", chirp_en); else passed++;
        total++; if (start_ctrl !== 32'h0) $display("FAIL cleared_table_start: got %0h exp 0", start_ctrl); else passed++;
        total++; if (delay !== 4'h0) $display("FAIL cleared_table_delay: got %0h exp 0", delay); else passed++;
        pulse();
        total++; if (done !== 1'b1) $display("FAIL cleared_table_done: got %0h exp 1", done); else passed++;
        step();
    endtask

    task automatic test_single();
        cfg_write(2'd0, 32'h100, 32'h200, 16'h10, 16'h0, 4'h2, 8'd3);
        last_idx = 2'd0; loop_en = 1'b0;
        kick();
        total++; if (busy !== 1'b1) $display("FAIL single_busy_n: got %0h exp 1", busy); else passed++;
        step();
        total++; if (chirp_en !== 1'b0) $display("FAIL single_en_n1: got %0h exp 0", chirp_en); else passed++;
        step();
        total++; if (chirp_en !== 1'b1) $display("FAIL single_en_n2: got %0h exp 1", chirp_en); else passed++;
        total++; if (start_ctrl !== 32'h100) $display("FAIL single_start: got %0h exp 100", start_ctrl); else passed++;
        total++; if (end_ctrl !== 32'h200) $display("FAIL single_end: got %0h exp 200", end_ctrl); else passed++;
        total++; if (prp_rate !== 16'h10) $display("FAIL single_prp: got %0h exp 10", prp_rate); else passed++;
        total++; if (delay !== 4'h2) $display("FAIL single_delay: got %0h exp 2", delay); else passed++;
        pulse(); pulse();
        total++; if (chirp_en !== 1'b1) $display("FAIL single_after2: got %0h exp 1", chirp_en); else passed++;
        pulse();
        total++; if (done !== 1'b1) $display("FAIL single_done: got %0h exp 1", done); else passed++;
        total++; if (start_ctrl !== 32'h0) $display("FAIL single_done_zero: got %0h exp 0", start_ctrl); else passed++;
        step();
        total++; if (done !== 1'b0) $display("FAIL single_done_width: got %0h exp 0", done); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL single_idle: got %0h exp 0", busy); else passed++;
    endtask

    task automatic test_sequence();
        cfg_write(2'd0, 32'h10, 32'h11, 16'h1, 16'h0, 4'h0, 8'd1);
        cfg_write(2'd1, 32'h20, 32'h21, 16'h2, 16'h0, 4'h0, 8'd2);
        last_idx = 2'd1; loop_en = 1'b1;
        done_snap = done_cnt;
        kick(); step(); step();
        total++; if (start_ctrl !== 32'h10) $display("FAIL seq_p0_start: got %0h exp 10", start_ctrl); else passed++;
        pulse(); step(); step();
        total++; if (profile_idx !== 2'd1) $display("FAIL seq_idx1: got %0h exp 1", profile_idx); else passed++;
        total++; if (start_ctrl !== 32'h20) $display("FAIL seq_p1_start: got %0h exp 20", start_ctrl); else passed++;
        pulse();
        total++; if (profile_idx !== 2'd1) $display("FAIL seq_p1_stay: got %0h exp 1", profile_idx); else passed++;
        pulse(); step(); step();
        total++; if (profile_idx !== 2'd0) $display("FAIL seq_wrap_idx: got %0h exp 0", profile_idx); else passed++;
        total++; if (start_ctrl !== 32'h10) $display("FAIL seq_wrap_start: got %0h exp 10", start_ctrl); else passed++;
        stop = 1'b1;
        step();
        stop = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL seq_stop_busy: got %0h exp 0", busy); else passed++;
        total++; if (chirp_en !== 1'b0) $display("FAIL seq_stop_en: got %0h exp 0", chirp_en); else passed++;
        step();
        total++; if (done_cnt !== done_snap) $display("FAIL seq_no_done: got %0d exp %0d", done_cnt, done_snap); else passed++;
    endtask

    task automatic test_repeat_zero();
        cfg_write(2'd0, 32'h40, 32'h41, 16'h4, 16'h0, 4'h1, 8'd0);
        last_idx = 2'd0; loop_en = 1'b0;
        nco_reset_in = 1'b1;
        kick(); step(); step(); step();
        total++; if (chirp_en !== 1'b1) $display("FAIL rep0_level_not_counted: got %0h exp 1", chirp_en); else passed++;
        total++; if (start_ctrl !== 32'h40) $display("FAIL rep0_start: got %0h exp 40", start_ctrl); else passed++;
        nco_reset_in = 1'b0;
        step();
        pulse();
        total++; if (done !== 1'b1) $display("FAIL rep0_one_sweep_done: got %0h exp 1", done); else passed++;
        step();
    endtask

    task automatic test_start_stop();
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL startstop_busy: got %0h exp 0", busy); else passed++;
        cfg_write(2'd0, 32'h55, 32'h56, 16'h5, 16'h0, 4'h0, 8'd2);
        last_idx = 2'd0; loop_en = 1'b0;
        kick(); step(); step();
        pulse();
        kick(); step();
        total++; if (chirp_en !== 1'b1) $display("FAIL start_in_run_ignored: got %0h exp 1", chirp_en); else passed++;
        pulse();
        total++; if (done !== 1'b1) $display("FAIL start_in_run_count_kept: got %0h exp 1", done); else passed++;
        step();
    endtask

    task automatic test_table_write();
        cfg_write(2'd0, 32'h1, 32'h200, 16'h1, 16'h0, 4'h0, 8'd1);
        cfg_write(2'd1, 32'h77, 32'h88, 16'h1, 16'h0, 4'h0, 8'd1);
        last_idx = 2'd1; loop_en = 1'b1;
        kick(); step(); step();
        cfg_write(2'd0, 32'h1, 32'h300, 16'h1, 16'h0, 4'h0, 8'd1);
        step();
        total++; if (end_ctrl !== 32'h200) $display("FAIL shadow_hold: got %0h exp 200", end_ctrl); else passed++;
        pulse(); step(); step();
        total++; if (end_ctrl !== 32'h88) $display("FAIL shadow_p1: got %0h exp 88", end_ctrl); else passed++;
        pulse(); step(); step();
        total++; if (end_ctrl !== 32'h300) $display("FAIL shadow_reload: got %0h exp 300", end_ctrl); else passed++;
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_sequence();
        test_repeat_zero();
        test_start_stop();
        test_table_write();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
